// File: rtl/clk_period_meter_if.sv
// clk_period_meter_if: control inputs and measurement results of the period meter
interface clk_period_meter_if #(
  parameter int WIDTH = 32
);
  logic             en;
  logic             sig_in;
  logic [WIDTH-1:0] period_cycles;
  logic [WIDTH-1:0] high_cycles;
  logic             valid;
  logic             timeout;
  logic             busy;
  modport master (
    output en, sig_in,
    input  period_cycles, high_cycles, valid, timeout, busy
  );
  modport slave (
    input  en, sig_in,
    output period_cycles, high_cycles, valid, timeout, busy
  );
endinterface

// File: rtl/clk_period_meter.sv
// clk_period_meter: measures period and high time of a slow input in clk cycles
module clk_period_meter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 50_000_000
) (
  input logic                clk,
  input logic                rst,
  clk_period_meter_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  localparam logic [WIDTH-1:0] tmo = WIDTH'(TIMEOUT);
  state_t           state, state_n;
  logic             s1, s2, s3;
  logic [WIDTH-1:0] cnt, cnt_n, hi_lat, hi_n, period, period_n, high, high_n;
  logic             valid, valid_n, timeout, timeout_n;
  logic             rise, fall;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  // Synchroniser plus one delay stage; both edges see the same fixed latency
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, s2, s3} <= '0;
    else {s1, s2, s3} <= {bus.sig_in, s1, s2};
  // Measurement state and result registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_lat  <= '0;
      period  <= '0;
      high    <= '0;
      valid   <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      hi_lat  <= hi_n;
      period  <= period_n;
      high    <= high_n;
      valid   <= valid_n;
      timeout <= timeout_n;
    end
  // Next state: arm on first rise, then every rise closes one period; a rise beats a timeout
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    hi_n      = hi_lat;
    period_n  = period;
    high_n    = high;
    valid_n   = 1'b0;
    timeout_n = timeout;
    if (!bus.en) begin
      state_n   = IDLE;
      cnt_n     = '0;
      hi_n      = '0;
      timeout_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n   = '0;
          hi_n    = '0;
          state_n = ARM;
        end
        ARM:
          if (rise) begin
            cnt_n   = WIDTH'(1);
            hi_n    = '0;
            state_n = MEASURE;
          end else if (cnt == tmo) begin
            timeout_n = 1'b1;
            cnt_n     = '0;
          end else cnt_n = cnt + 1'b1;
        MEASURE:
          if (rise) begin
            period_n  = cnt;
            high_n    = hi_lat;
            valid_n   = 1'b1;
            timeout_n = 1'b0;
            cnt_n     = WIDTH'(1);
            hi_n      = '0;
          end else if (cnt == tmo) begin
            timeout_n = 1'b1;
            cnt_n     = '0;
            state_n   = ARM;
          end else begin
            cnt_n = cnt + 1'b1;
            hi_n  = fall ? cnt : hi_lat;
          end
        default: state_n = IDLE;
      endcase
    end
  end
  assign bus.period_cycles = period;
  assign bus.high_cycles   = high;
  assign bus.valid         = valid;
  assign bus.timeout       = timeout;
  assign bus.busy          = state != IDLE;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: directed checks of period/high measurement, timeout, enable and reset
module tb_clk_period_meter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int nv, fp, fh, lp, lh, mng, mxg;
  clk_period_meter_if #(.WIDTH(32)) bus ();
  clk_period_meter #(.WIDTH(32), .TIMEOUT(20)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick(input logic s);
    bus.sig_in = s;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input int hi, input int lo, input int reps,
                     output int n, output int p0, output int h0, output int p1, output int h1,
                     output int gmin, output int gmax);
    int t, last;
    n = 0; p0 = -1; h0 = -1; p1 = -1; h1 = -1; gmin = 1 << 30; gmax = 0; t = 0; last = -1;
    for (int r = 0; r < reps; r++)
      for (int i = 0; i < hi + lo; i++) begin
        tick(i < hi);
        t++;
        if (bus.valid) begin
          if (n == 0) begin p0 = bus.period_cycles; h0 = bus.high_cycles; end
          p1 = bus.period_cycles;
          h1 = bus.high_cycles;
          if (last >= 0) begin
            gmin = (t - last < gmin) ? t - last : gmin;
            gmax = (t - last > gmax) ? t - last : gmax;
          end
          last = t;
          n++;
        end
      end
  endtask
  initial begin
    bus.en = 1'b0;
    bus.sig_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_period", bus.period_cycles, 0);
    chk("rst_high", bus.high_cycles, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_timeout", bus.timeout, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    bus.en = 1'b1;
    repeat (4) tick(0);
    chk("arm_busy", bus.busy, 1);
    run(4, 4, 5, nv, fp, fh, lp, lh, mng, mxg);
    chk("t1_nvalid", nv, 4);
    chk("t1_first_period", fp, 8);
    chk("t1_first_high", fh, 4);
    chk("t1_last_period", lp, 8);
    chk("t1_last_high", lh, 4);
    chk("t1_gap_min", mng, 8);
    chk("t1_gap_max", mxg, 8);
    run(3, 7, 1, nv, fp, fh, lp, lh, mng, mxg);
    chk("t2_sync_nvalid", nv, 1);
    chk("t2_sync_period", fp, 8);
    run(3, 7, 4, nv, fp, fh, lp, lh, mng, mxg);
    chk("t2_nvalid", nv, 4);
    chk("t2_first_period", fp, 10);
    chk("t2_first_high", fh, 3);
    chk("t2_last_period", lp, 10);
    chk("t2_last_high", lh, 3);
    chk("t2_gap", mng, 10);
    chk("t2_busy", bus.busy, 1);
    repeat (12) tick(0);
    chk("t3_before_timeout", bus.timeout, 0);
    tick(0);
    chk("t3_timeout", bus.timeout, 1);
    chk("t3_busy", bus.busy, 1);
    repeat (10) tick(0);
    chk("t3_hold_timeout", bus.timeout, 1);
    chk("t3_hold_period", bus.period_cycles, 10);
    chk("t3_hold_high", bus.high_cycles, 3);
    run(4, 4, 3, nv, fp, fh, lp, lh, mng, mxg);
    chk("t3_restart_nvalid", nv, 2);
    chk("t3_restart_period", lp, 8);
    chk("t3_restart_high", lh, 4);
    chk("t3_restart_timeout", bus.timeout, 0);
    run(10, 10, 1, nv, fp, fh, lp, lh, mng, mxg);
    chk("t4_sync_period", fp, 8);
    run(10, 10, 4, nv, fp, fh, lp, lh, mng, mxg);
    chk("t4_nvalid", nv, 4);
    chk("t4_first_period", fp, 20);
    chk("t4_last_period", lp, 20);
    chk("t4_last_high", lh, 10);
    chk("t4_gap", mxg, 20);
    chk("t4_timeout", bus.timeout, 0);
    repeat (3) tick(1);
    chk("t5_valid_before_drop", bus.valid, 1);
    chk("t5_period_before_drop", bus.period_cycles, 20);
    bus.en = 1'b0;
    tick(1);
    chk("t5_busy", bus.busy, 0);
    chk("t5_valid", bus.valid, 0);
    chk("t5_period_hold", bus.period_cycles, 20);
    chk("t5_high_hold", bus.high_cycles, 10);
    chk("t5_timeout", bus.timeout, 0);
    bus.en = 1'b1;
    repeat (6) tick(0);
    run(4, 4, 3, nv, fp, fh, lp, lh, mng, mxg);
    chk("t5_reen_nvalid", nv, 2);
    chk("t5_reen_period", lp, 8);
    chk("t5_reen_high", lh, 4);
    repeat (2) tick(1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_period", bus.period_cycles, 0);
    chk("t6_high", bus.high_cycles, 0);
    chk("t6_valid", bus.valid, 0);
    chk("t6_timeout", bus.timeout, 0);
    chk("t6_busy", bus.busy, 0);
    repeat (2) tick(0);
    rst = 1'b0;
    chk("t6_release_busy", bus.busy, 0);
    tick(0);
    chk("t6_arm_busy", bus.busy, 1);
    repeat (3) tick(0);
    run(4, 4, 3, nv, fp, fh, lp, lh, mng, mxg);
    chk("t6_nvalid", nv, 2);
    chk("t6_first_period", fp, 8);
    chk("t6_last_high", lh, 4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
